// File: rtl/en_extmem_port.sv
// External-memory port for ElectronNest: BRAM, boot-token sequencer, load responder with skid,
// and a store write buffer with back-pressure and store-to-load forwarding.
module en_extmem_port #(
  parameter int DEPTH        = 1024,
  parameter int BOOT_PAD     = 3,
  parameter int BOOT_WORDS   = 5,
  parameter int ST_DEPTH     = 4,
  parameter int WIDTH_DATA   = 32,
  parameter int WIDTH_EXADDR = 16
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 I_Boot,
  input  logic                                 I_Init_We,
  input  logic [WIDTH_EXADDR-1:0]              I_Init_Addr,
  input  logic [WIDTH_DATA-1:0]                I_Init_Data,
  input  logic                                 I_Ld_Req,
  input  logic [WIDTH_EXADDR-1:0]              I_Ld_Addr,
  output logic [4+WIDTH_EXADDR+WIDTH_DATA-1:0] O_Ld_FTk,
  input  logic [3:0]                           I_Ld_BTk,
  input  logic                                 I_St_Req,
  input  logic [WIDTH_EXADDR-1:0]              I_St_Addr,
  input  logic [4+WIDTH_EXADDR+WIDTH_DATA-1:0] I_St_FTk,
  output logic [3:0]                           O_St_BTk,
  output logic                                 O_Ld_Ovf,
  output logic                                 O_Busy,
  output logic [1:0]                           O_Dbg_State
);
  // Token layout, MSB first: FTk = {v, a, r, c, i[WIDTH_EXADDR], d[WIDTH_DATA]}, BTk = {n, t, v, c}.
  // Handshake: a token with v=1 is consumed on a clock edge where BTk.n=0; while n=1 it is held
  // unchanged. Store requests are accepted when I_St_Req & FTk.v & ~O_St_BTk.n.
  localparam int AW    = $clog2(DEPTH);
  localparam int FW    = 4 + WIDTH_EXADDR + WIDTH_DATA;
  localparam int TOTAL = BOOT_PAD + BOOT_WORDS;
  localparam int CW    = $clog2(TOTAL + 1);
  localparam int SW    = $clog2(ST_DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PAD  = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_RUN  = 2'd3;

  logic [1:0]              r_state;
  logic [CW-1:0]           r_cnt;
  logic [FW-1:0]           r_ld_ftk;
  logic                    r_p_v;
  logic [WIDTH_EXADDR-1:0] r_p_addr;
  logic                    r_p_fwd;
  logic [WIDTH_DATA-1:0]   r_p_fwd_d;
  logic                    r_skid_v;
  logic [WIDTH_EXADDR-1:0] r_skid_addr;
  logic                    r_ovf;
  logic [WIDTH_DATA-1:0]   r_mem [DEPTH];
  logic [WIDTH_DATA-1:0]   r_mem_q;
  logic [AW-1:0]           r_sb_addr [ST_DEPTH];
  logic [WIDTH_DATA-1:0]   r_sb_data [ST_DEPTH];
  logic [SW-1:0]           r_wp;
  logic [SW-1:0]           r_rp;
  logic [SW:0]             r_sb_cnt;
  logic                    r_sb_full;

  logic                    w_stall, w_adv, w_run, w_idle, w_boot_st, w_boot_go;
  logic                    w_ld_issue, w_boot_rd, w_init_wr, w_sb_push, w_sb_pop;
  logic [WIDTH_EXADDR-1:0] w_ld_addr;
  logic [CW-1:0]           w_boot_next;
  logic [AW-1:0]           w_boot_addr;
  logic                    w_mem_we, w_mem_re;
  logic [AW-1:0]           w_mem_addr;
  logic [WIDTH_DATA-1:0]   w_mem_wdata;
  logic                    w_fwd_hit;
  logic [WIDTH_DATA-1:0]   w_fwd_d;
  logic [SW-1:0]           w_fwd_idx;
  logic [SW:0]             w_sb_cnt_nxt;
  logic [FW-1:0]           w_boot_tok, w_run_tok;
  logic                    w_unused;

  assign w_stall   = r_ld_ftk[FW-1] & I_Ld_BTk[3];
  assign w_adv     = ~w_stall;
  assign w_run     = (r_state == S_RUN);
  assign w_idle    = (r_state == S_IDLE);
  assign w_boot_st = (r_state == S_PAD) | (r_state == S_DATA);
  assign w_boot_go = w_idle & I_Boot;

  // A parked skid request always issues ahead of a new one.
  assign w_ld_issue = w_run & w_adv & (r_skid_v | I_Ld_Req);
  assign w_ld_addr  = r_skid_v ? r_skid_addr : I_Ld_Addr;

  // Boot data words are read one cycle ahead of the token that carries them.
  assign w_boot_next = w_boot_go ? '0 : r_cnt + 1'b1;
  assign w_boot_addr = AW'(w_boot_next) - AW'(BOOT_PAD);
  assign w_boot_rd   = (w_boot_st & w_adv) | w_boot_go;
  assign w_init_wr   = w_idle & I_Init_We & ~w_boot_rd;

  assign w_sb_push = I_St_Req & I_St_FTk[FW-1] & ~r_sb_full;
  assign w_sb_pop  = (w_run | w_idle) & (r_sb_cnt != '0) & ~w_ld_issue & ~w_boot_rd & ~w_init_wr;

  assign w_mem_re = w_ld_issue | w_boot_rd;
  assign w_mem_we = w_init_wr | w_sb_pop;

  always_comb begin
    w_mem_addr  = '0;
    w_mem_wdata = '0;
    if (w_ld_issue) begin
      w_mem_addr = w_ld_addr[AW-1:0];
    end else if (w_boot_rd) begin
      w_mem_addr = w_boot_addr;
    end else if (w_init_wr) begin
      w_mem_addr  = I_Init_Addr[AW-1:0];
      w_mem_wdata = I_Init_Data;
    end else if (w_sb_pop) begin
      w_mem_addr  = r_sb_addr[r_rp];
      w_mem_wdata = r_sb_data[r_rp];
    end
  end

  // Walk entries oldest to newest so the newest match wins; a same-cycle push is newest of all.
  always_comb begin
    w_fwd_hit = 1'b0;
    w_fwd_d   = '0;
    w_fwd_idx = '0;
    for (int k = 0; k < ST_DEPTH; k++) begin
      w_fwd_idx = r_rp + SW'(k);
      if (((SW+1)'(k) < r_sb_cnt) && (r_sb_addr[w_fwd_idx] == w_ld_addr[AW-1:0])) begin
        w_fwd_hit = 1'b1;
        w_fwd_d   = r_sb_data[w_fwd_idx];
      end
    end
    if (w_sb_push && (I_St_Addr[AW-1:0] == w_ld_addr[AW-1:0])) begin
      w_fwd_hit = 1'b1;
      w_fwd_d   = I_St_FTk[WIDTH_DATA-1:0];
    end
  end

  always_comb begin
    w_sb_cnt_nxt = r_sb_cnt;
    if (w_sb_push && !w_sb_pop)      w_sb_cnt_nxt = r_sb_cnt + 1'b1;
    else if (w_sb_pop && !w_sb_push) w_sb_cnt_nxt = r_sb_cnt - 1'b1;
  end

  assign w_boot_tok = {1'b1, (r_cnt == '0), 2'b00, {WIDTH_EXADDR{1'b0}},
                       (r_cnt < CW'(BOOT_PAD)) ? {WIDTH_DATA{1'b0}} : r_mem_q};
  assign w_run_tok  = {1'b1, 3'b000, r_p_addr, r_p_fwd ? r_p_fwd_d : r_mem_q};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_ld_ftk <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (I_Boot) begin
            r_state <= (BOOT_PAD > 0) ? S_PAD : S_DATA;
            r_cnt   <= '0;
          end
        end
        S_PAD, S_DATA: begin
          if (w_adv) begin
            r_ld_ftk <= w_boot_tok;
            r_cnt    <= w_boot_next;
            if (r_cnt == CW'(TOTAL - 1))         r_state <= S_RUN;
            else if (r_cnt == CW'(BOOT_PAD - 1)) r_state <= S_DATA;
          end
        end
        default: begin
          if (w_adv) r_ld_ftk <= r_p_v ? w_run_tok : '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_p_v       <= 1'b0;
      r_p_addr    <= '0;
      r_p_fwd     <= 1'b0;
      r_p_fwd_d   <= '0;
      r_skid_v    <= 1'b0;
      r_skid_addr <= '0;
      r_ovf       <= 1'b0;
    end else if (w_run) begin
      if (w_adv) begin
        r_p_v <= w_ld_issue;
        if (w_ld_issue) begin
          r_p_addr  <= w_ld_addr;
          r_p_fwd   <= w_fwd_hit;
          r_p_fwd_d <= w_fwd_d;
        end
        // The skid just issued; a request arriving now takes its place.
        if (r_skid_v) begin
          r_skid_v    <= I_Ld_Req;
          r_skid_addr <= I_Ld_Addr;
        end
      end else if (I_Ld_Req) begin
        if (r_skid_v) begin
          r_ovf <= 1'b1;
        end else begin
          r_skid_v    <= 1'b1;
          r_skid_addr <= I_Ld_Addr;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wp      <= '0;
      r_rp      <= '0;
      r_sb_cnt  <= '0;
      r_sb_full <= 1'b0;
    end else begin
      if (w_sb_push) r_wp <= r_wp + 1'b1;
      if (w_sb_pop)  r_rp <= r_rp + 1'b1;
      r_sb_cnt  <= w_sb_cnt_nxt;
      r_sb_full <= (w_sb_cnt_nxt == (SW+1)'(ST_DEPTH));
    end
  end

  // Storage arrays carry no reset; BRAM contents survive a reset.
  always_ff @(posedge clock) begin
    if (w_mem_we)      r_mem[w_mem_addr] <= w_mem_wdata;
    else if (w_mem_re) r_mem_q <= r_mem[w_mem_addr];
    if (w_sb_push) begin
      r_sb_addr[r_wp] <= I_St_Addr[AW-1:0];
      r_sb_data[r_wp] <= I_St_FTk[WIDTH_DATA-1:0];
    end
  end

  assign O_Ld_FTk    = r_ld_ftk;
  assign O_St_BTk    = {r_sb_full, 3'b000};
  assign O_Ld_Ovf    = r_ovf;
  assign O_Busy      = ~w_idle | (r_sb_cnt != '0);
  assign O_Dbg_State = r_state;

  assign w_unused = ^{I_Ld_BTk[2:0], I_St_FTk[FW-2:WIDTH_DATA],
                      I_St_Addr[WIDTH_EXADDR-1:AW], I_Init_Addr[WIDTH_EXADDR-1:AW]};
endmodule
